// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: carries decode-stage branch predictions through
// the EX and MEM register stages, resolves them in MEM against the captured
// ALU zero flag, and reports the outcome back to the predictor. A mispredict
// raises flush, supplies the corrected fetch PC and kills the younger EX entry.
// Saturating counters track resolved branches and mispredictions.
//
// Handshake: there is no valid/ready pair. stall is a global hold. While it
// is high every register keeps its value and no report is made. A MEM branch
// reports once, in the cycle it leaves MEM with stall low.
module branch_resolve_unit #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             stall,
   input  logic             id_valid,
   input  logic [1:0]       id_branch_op,
   input  logic             id_pred_taken,
   input  logic [PC_W-1:0]  id_pc,
   input  logic [PC_W-1:0]  id_target,
   input  logic             ex_zero,
   output logic [1:0]       pred_result,
   output logic [PC_W-1:0]  pc_mem,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam logic [1:0] OP_BREQ = 2'b01;
   localparam logic [1:0] OP_BRNE = 2'b10;

   localparam logic [1:0] PR_NO_PRED    = 2'b00;
   localparam logic [1:0] PR_RIGHT_PRED = 2'b01;
   localparam logic [1:0] PR_WRONG_PRED = 2'b10;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // EX stage entry
   logic            ex_valid_q;
   logic [1:0]      ex_op_q;
   logic            ex_pred_q;
   logic [PC_W-1:0] ex_pc_q;
   logic [PC_W-1:0] ex_target_q;

   // MEM stage entry (EX entry plus the zero flag captured while in EX)
   logic            mem_valid_q;
   logic [1:0]      mem_op_q;
   logic            mem_pred_q;
   logic [PC_W-1:0] mem_pc_q;
   logic [PC_W-1:0] mem_target_q;
   logic            mem_zero_q;

   logic [CNT_W-1:0] branch_cnt_q;
   logic [CNT_W-1:0] mispred_cnt_q;
   logic [CNT_W-1:0] branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_d;

   logic mem_is_branch;
   logic mem_actual;
   logic resolve;
   logic mispredict;

   // Resolve the MEM entry and form the report outputs
   always_comb begin
      mem_is_branch = mem_valid_q && ((mem_op_q == OP_BREQ) || (mem_op_q == OP_BRNE));
      mem_actual    = (mem_op_q == OP_BREQ) ? mem_zero_q : !mem_zero_q;
      resolve       = mem_is_branch && !stall;
      mispredict    = resolve && (mem_actual != mem_pred_q);

      pred_result = PR_NO_PRED;
      if (resolve) begin
         pred_result = mispredict ? PR_WRONG_PRED : PR_RIGHT_PRED;
      end
      flush       = mispredict;
      redirect_pc = mem_actual ? mem_target_q : (mem_pc_q + PC_W'(4));
      pc_mem      = mem_pc_q;
   end

   // Saturating next values of the statistics counters
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (resolve && (branch_cnt_q != CNT_MAX)) begin
         branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
         mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      end
   end

   // Stage registers and counters; a flush empties both stages
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_valid_q    <= 1'b0;
         ex_op_q       <= 2'b00;
         ex_pred_q     <= 1'b0;
         ex_pc_q       <= '0;
         ex_target_q   <= '0;
         mem_valid_q   <= 1'b0;
         mem_op_q      <= 2'b00;
         mem_pred_q    <= 1'b0;
         mem_pc_q      <= '0;
         mem_target_q  <= '0;
         mem_zero_q    <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else if (!stall) begin
         ex_op_q       <= id_branch_op;
         ex_pred_q     <= id_pred_taken;
         ex_pc_q       <= id_pc;
         ex_target_q   <= id_target;
         mem_op_q      <= ex_op_q;
         mem_pred_q    <= ex_pred_q;
         mem_pc_q      <= ex_pc_q;
         mem_target_q  <= ex_target_q;
         mem_zero_q    <= ex_zero;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
         if (mispredict) begin
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
         end else begin
            ex_valid_q  <= id_valid;
            mem_valid_q <= ex_valid_q;
         end
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
